// File: rtl/channel_modulator_if.sv
// Sample-stream bundle for channel_modulator: upstream I/Q ready/valid, the
// phase-increment load strobe, and the downstream I/Q ready/valid stream.
interface channel_modulator_if #(
  parameter int WIDTH = 16
);
  logic signed [WIDTH-1:0] i_inph;
  logic signed [WIDTH-1:0] i_quad;
  logic                    i_valid;
  logic                    o_ready;
  logic [11:0]             i_phase_inc;
  logic                    i_phase_inc_valid;
  logic signed [WIDTH-1:0] o_inph;
  logic signed [WIDTH-1:0] o_quad;
  logic                    o_valid;
  logic                    i_ready;

  modport slave (
    input  i_inph, i_quad, i_valid, i_phase_inc, i_phase_inc_valid, i_ready,
    output o_ready, o_inph, o_quad, o_valid
  );

  modport master (
    output i_inph, i_quad, i_valid, i_phase_inc, i_phase_inc_valid, i_ready,
    input  o_ready, o_inph, o_quad, o_valid
  );
endinterface

// File: rtl/channel_modulator.sv
// Streaming complex mixer: each accepted I/Q sample is rotated by exp(j*2*pi*phi/4096).
// Define CHANNEL_MODULATOR_SATURATE_EN to saturate the rounded result instead of wrapping.
module channel_modulator #(
  parameter int WIDTH        = 16,
  parameter int NUM_CHANNELS = 2048
) (
  input  logic               i_clock,
  input  logic               i_reset,
  channel_modulator_if.slave bus
);

  localparam int PHASE_W = $clog2(2 * NUM_CHANNELS);
  localparam int QTR     = 2 ** (PHASE_W - 2);

  typedef logic signed [WIDTH-1:0]   sample_t;
  typedef logic signed [2*WIDTH-1:0] prod_t;
  typedef logic signed [2*WIDTH:0]   sum_t;

  localparam logic signed [127:0] FX_PI   = 128'sh3243F6A8885A308D;
  localparam logic signed [127:0] FX_ONE  = 128'sd1 <<< 60;
  localparam logic signed [127:0] FX_HALF = 128'sd1 <<< 59;
  localparam sum_t ROUND_BIAS = (2*WIDTH+1)'(1) <<< (WIDTH - 2);
`ifdef CHANNEL_MODULATOR_SATURATE_EN
  localparam logic signed [WIDTH+1:0] SAT_MAX = (WIDTH+2)'((1 <<< (WIDTH - 1)) - 1);
  localparam logic signed [WIDTH+1:0] SAT_MIN = (WIDTH+2)'(-(1 <<< (WIDTH - 1)));
`endif

  // Elaboration-time cosine in 2^-60 fixed point; past 45 degrees the sine
  // series of the complement angle is used so both series converge quickly.
  function automatic sample_t quarter_cos(input int k);
    logic signed [127:0] x, x2, term, sum, den, amp;
    logic use_sin;
    int   m;
    use_sin = (k > QTR / 2);
    m       = use_sin ? QTR - k : k;
    x       = (FX_PI * 128'(m)) >>> (PHASE_W - 1);
    x2      = (x * x) >>> 60;
    term    = use_sin ? x : FX_ONE;
    sum     = term;
    for (int n = 1; n <= 12; n++) begin
      den  = use_sin ? 128'(2*n*(2*n+1)) : 128'((2*n-1)*(2*n));
      term = -(((term * x2) >>> 60) / den);
      sum  = sum + term;
    end
    amp = 128'((1 <<< (WIDTH - 1)) - 1);
    return WIDTH'((sum * amp + FX_HALF) >>> 60);
  endfunction

  function automatic sample_t reduce(input sum_t sum);
    sum_t biased;
`ifdef CHANNEL_MODULATOR_SATURATE_EN
    logic signed [WIDTH+1:0] rounded;
`endif
    biased = sum + ROUND_BIAS;
`ifdef CHANNEL_MODULATOR_SATURATE_EN
    rounded = (WIDTH+2)'(biased >>> (WIDTH - 1));
    if (rounded > SAT_MAX)      reduce = SAT_MAX[WIDTH-1:0];
    else if (rounded < SAT_MIN) reduce = SAT_MIN[WIDTH-1:0];
    else                        reduce = rounded[WIDTH-1:0];
`else
    reduce = WIDTH'(biased >>> (WIDTH - 1));
`endif
  endfunction

  sample_t rom [QTR];
  for (genvar k = 0; k < QTR; k++) begin : g_rom
    localparam sample_t ROM_VAL = quarter_cos(k);
    assign rom[k] = ROM_VAL;
  end

  logic               en;
  logic               accept;
  logic [PHASE_W-1:0] phase_acc;
  logic [PHASE_W-1:0] phase_inc;

  logic               s0_valid;
  sample_t            s0_inph, s0_quad;
  logic [PHASE_W-1:0] s0_phase;
  logic               s1_valid;
  sample_t            s1_inph, s1_quad, s1_cos, s1_sin;
  logic               s2_valid;
  prod_t              s2_ic, s2_qs, s2_is, s2_qc;
  logic               out_valid;
  sample_t            out_inph, out_quad;

  logic [1:0]         quad;
  logic [PHASE_W-3:0] idx, idx_mirror;
  sample_t            c_mag, s_mag, cos_v, sin_v;
  sum_t               sum_i, sum_q;

  assign en          = !out_valid || bus.i_ready;
  assign accept      = bus.i_valid && en;
  assign bus.o_ready = en;
  assign bus.o_valid = out_valid;
  assign bus.o_inph  = out_inph;
  assign bus.o_quad  = out_quad;

  // A load restarts the accumulator and wins over a simultaneous accept.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_acc <= '0;
      phase_inc <= '0;
    end else if (bus.i_phase_inc_valid) begin
      phase_inc <= bus.i_phase_inc;
      phase_acc <= '0;
    end else if (accept) begin
      phase_acc <= phase_acc + phase_inc;
    end
  end

  assign quad       = s0_phase[PHASE_W-1 -: 2];
  assign idx        = s0_phase[PHASE_W-3:0];
  assign idx_mirror = -idx;

  // Sine at idx is cosine at the mirrored index; index 0 mirrors to the
  // quadrant boundary, which lies outside the table and is exactly zero.
  always_comb begin
    c_mag = rom[idx];
    s_mag = (idx == '0) ? '0 : rom[idx_mirror];
    cos_v = c_mag;
    sin_v = s_mag;
    case (quad)
      2'd0: begin cos_v = c_mag;  sin_v = s_mag;  end
      2'd1: begin cos_v = -s_mag; sin_v = c_mag;  end
      2'd2: begin cos_v = -c_mag; sin_v = -s_mag; end
      2'd3: begin cos_v = s_mag;  sin_v = -c_mag; end
    endcase
  end

  always_comb begin
    sum_i = {s2_ic[2*WIDTH-1], s2_ic} - {s2_qs[2*WIDTH-1], s2_qs};
    sum_q = {s2_is[2*WIDTH-1], s2_is} + {s2_qc[2*WIDTH-1], s2_qc};
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      s0_valid  <= 1'b0;
      s0_inph   <= '0;
      s0_quad   <= '0;
      s0_phase  <= '0;
      s1_valid  <= 1'b0;
      s1_inph   <= '0;
      s1_quad   <= '0;
      s1_cos    <= '0;
      s1_sin    <= '0;
      s2_valid  <= 1'b0;
      s2_ic     <= '0;
      s2_qs     <= '0;
      s2_is     <= '0;
      s2_qc     <= '0;
      out_valid <= 1'b0;
      out_inph  <= '0;
      out_quad  <= '0;
    end else if (en) begin
      s0_valid  <= accept;
      s0_inph   <= bus.i_inph;
      s0_quad   <= bus.i_quad;
      s0_phase  <= phase_acc;
      s1_valid  <= s0_valid;
      s1_inph   <= s0_inph;
      s1_quad   <= s0_quad;
      s1_cos    <= cos_v;
      s1_sin    <= sin_v;
      s2_valid  <= s1_valid;
      s2_ic     <= prod_t'(s1_inph) * prod_t'(s1_cos);
      s2_qs     <= prod_t'(s1_quad) * prod_t'(s1_sin);
      s2_is     <= prod_t'(s1_inph) * prod_t'(s1_sin);
      s2_qc     <= prod_t'(s1_quad) * prod_t'(s1_cos);
      out_valid <= s2_valid;
      out_inph  <= reduce(sum_i);
      out_quad  <= reduce(sum_q);
    end
  end

endmodule

// File: tb/tb_channel_modulator.sv
// Directed bench for channel_modulator: idle, zero shift, quarter rotation,
// backpressure, rounding/saturation at 45 degrees and reset mid-stream.
module tb_channel_modulator;
  localparam int WIDTH = 16;
`ifdef CHANNEL_MODULATOR_SATURATE_EN
  localparam int SAT_Q = -32768;
`else
  localparam int SAT_Q = 19196;
`endif

  logic i_clock;
  logic i_reset;
  int   checks = 0;
  int   errors = 0;
  int   idle_valid;
  int   waited;

  channel_modulator_if #(.WIDTH(WIDTH)) bus ();

  channel_modulator #(.WIDTH(WIDTH), .NUM_CHANNELS(2048)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (bus)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    @(negedge i_clock);
  endtask

  task automatic applyStimulus(input logic valid, input int inph, input int quad, input logic ready);
    bus.i_valid = valid;
    bus.i_inph  = WIDTH'(inph);
    bus.i_quad  = WIDTH'(quad);
    bus.i_ready = ready;
  endtask

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic loadInc(input int inc);
    bus.i_phase_inc       = 12'(inc);
    bus.i_phase_inc_valid = 1'b1;
    tick();
    bus.i_phase_inc_valid = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int budget, output int n);
    n = 0;
    while (!bus.o_valid && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_timeout"}, bus.o_valid, 1);
  endtask

  // Sample n of a stream with increment 1024 sits n quarter turns round.
  task automatic rotExpected(input int n, input int x, output int ei, output int eq);
    case (n % 4)
      0:       begin ei = x;  eq = 0;  end
      1:       begin ei = 0;  eq = x;  end
      2:       begin ei = -x; eq = 0;  end
      default: begin ei = 0;  eq = -x; end
    endcase
  endtask

  task automatic streamSamples(input string tag, input int count, input int base, input int step,
                               input int stall_start, input int stall_len);
    int sent, got, cyc, stall_seen, ei, eq;
    sent = 0; got = 0; cyc = 0; stall_seen = 0;
    while (got < count && cyc < 200) begin
      applyStimulus(sent < count, base + sent * step, 0,
                    !(cyc >= stall_start && cyc < stall_start + stall_len));
      #1;
      rotExpected(got, base + got * step, ei, eq);
      if (bus.o_valid && !bus.i_ready) begin
        stall_seen++;
        checkOutput({tag, "_stall_o_ready"}, bus.o_ready, 0);
        checkOutput({tag, "_hold_inph"}, bus.o_inph, ei);
        checkOutput({tag, "_hold_quad"}, bus.o_quad, eq);
      end
      if (bus.o_valid && bus.i_ready) begin
        checkOutput({tag, "_inph"}, bus.o_inph, ei);
        checkOutput({tag, "_quad"}, bus.o_quad, eq);
        got++;
      end
      if (bus.i_valid && bus.o_ready) sent++;
      tick();
      cyc++;
    end
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput({tag, "_count"}, got, count);
    checkOutput({tag, "_stall_cycles"}, stall_seen, stall_len);
  endtask

  initial begin
    applyStimulus(1'b0, 0, 0, 1'b1);
    bus.i_phase_inc       = '0;
    bus.i_phase_inc_valid = 1'b0;
    i_reset = 1'b0;
    repeat (3) tick();
    checkOutput("rst_o_valid", bus.o_valid, 0);
    checkOutput("rst_o_inph", bus.o_inph, 0);
    checkOutput("rst_o_quad", bus.o_quad, 0);
    i_reset = 1'b1;
    #1;
    checkOutput("rst_o_ready", bus.o_ready, 1);

    $display("[TB] idle");
    idle_valid = 0;
    repeat (100) begin
      tick();
      if (bus.o_valid) idle_valid++;
    end
    checkOutput("idle_no_output", idle_valid, 0);

    $display("[TB] zero shift");
    applyStimulus(1'b1, 1000, -500, 1'b1);
    #1;
    checkOutput("zero_o_ready", bus.o_ready, 1);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      checkOutput("zero_latency_wait", bus.o_valid, 0);
      tick();
    end
    checkOutput("zero_latency_valid", bus.o_valid, 1);
    checkOutput("zero_inph", bus.o_inph, 1000);
    checkOutput("zero_quad", bus.o_quad, -500);
    tick();
    checkOutput("zero_drained", bus.o_valid, 0);

    $display("[TB] quarter rotation");
    loadInc(1024);
    streamSamples("rot", 4, 1000, 0, -1, 0);

    $display("[TB] backpressure");
    loadInc(1024);
    streamSamples("bp", 10, 100, 100, 6, 8);

    $display("[TB] rounding and saturation at 45 degrees");
    loadInc(512);
    applyStimulus(1'b1, 1000, 0, 1'b1);
    tick();
    applyStimulus(1'b1, -32768, -32768, 1'b1);
    tick();
    applyStimulus(1'b0, 0, 0, 1'b1);
    waitValid("sat_first", 10, waited);
    checkOutput("sat_latency", waited, 2);
    checkOutput("sat_first_inph", bus.o_inph, 1000);
    checkOutput("sat_first_quad", bus.o_quad, 0);
    tick();
    checkOutput("sat_second_valid", bus.o_valid, 1);
    checkOutput("sat_second_inph", bus.o_inph, 0);
    checkOutput("sat_second_quad", bus.o_quad, SAT_Q);
    tick();

    $display("[TB] reset mid-stream");
    loadInc(1024);
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b1, 1000, 0, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 0, 0, 1'b1);
    checkOutput("mid_pre_valid", bus.o_valid, 1);
    checkOutput("mid_pre_inph", bus.o_inph, 0);
    checkOutput("mid_pre_quad", bus.o_quad, 1000);
    #2;
    i_reset = 1'b0;
    #1;
    checkOutput("mid_rst_valid", bus.o_valid, 0);
    checkOutput("mid_rst_inph", bus.o_inph, 0);
    checkOutput("mid_rst_quad", bus.o_quad, 0);
    @(negedge i_clock);
    i_reset = 1'b1;
    applyStimulus(1'b1, 1234, -4321, 1'b1);
    tick();
    tick();
    applyStimulus(1'b0, 0, 0, 1'b1);
    waitValid("post_rst", 10, waited);
    checkOutput("post_rst_latency", waited, 2);
    checkOutput("post_rst_inph0", bus.o_inph, 1234);
    checkOutput("post_rst_quad0", bus.o_quad, -4321);
    tick();
    checkOutput("post_rst_valid1", bus.o_valid, 1);
    checkOutput("post_rst_inph1", bus.o_inph, 1234);
    checkOutput("post_rst_quad1", bus.o_quad, -4321);
    tick();
    checkOutput("post_rst_drained", bus.o_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
